// File: rtl/sobel_pkg.sv
// Shared types for the Sobel 3x3 window generator: pixel width, FSM states,
// packed 9-pixel window (index k holds pk) and the per-accept window shift.
package sobel_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } sobel_state_e;

  typedef logic [8:0][PIX_W-1:0] sobel_win_t;

  // Each row slides left; the new column is top/mid/bot entering at p2/p5/p8.
  function automatic sobel_win_t sobel_shift(input sobel_win_t w, input pix_t top,
                                             input pix_t mid, input pix_t bot);
    sobel_win_t s;
    s = w;
    for (int r = 0; r < 3; r++) begin
      s[3*r]     = w[3*r+1];
      s[3*r+1]   = w[3*r+2];
    end
    s[2] = top;
    s[5] = mid;
    s[8] = bot;
    return s;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage: registered write, combinational read so the
// old pixel at addr_i is available in the same cycle it gets overwritten.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wr_data_i,
  output logic [PIX_W-1:0] rd_data_o
);

  logic [PIX_W-1:0] r_mem [DEPTH];

  assign rd_data_o = r_mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows for a Sobel stage.
// Optional SOBEL_WINDOW_SOF_EN adds sof_i to force an accepted pixel to (0,0).
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk_i,
  input  logic             reset_i,
`ifdef SOBEL_WINDOW_SOF_EN
  input  logic             sof_i,
`endif
  input  logic [PIX_W-1:0] pix_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic [PIX_W-1:0] p0_o,
  output logic [PIX_W-1:0] p1_o,
  output logic [PIX_W-1:0] p2_o,
  output logic [PIX_W-1:0] p3_o,
  output logic [PIX_W-1:0] p4_o,
  output logic [PIX_W-1:0] p5_o,
  output logic [PIX_W-1:0] p6_o,
  output logic [PIX_W-1:0] p7_o,
  output logic [PIX_W-1:0] p8_o,
  output logic             win_valid_o,
  input  logic             win_ready_i
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  sobel_state_e     r_state, w_state_next, w_state;
  logic [COL_W-1:0] r_col, w_col_next, w_col;
  logic [ROW_W-1:0] r_row, w_row_next, w_row;
  logic             r_win_valid, w_win_valid_next;
  sobel_win_t       r_win;

  logic             w_accept;
  logic             w_sof;
  logic             w_load;
  logic [PIX_W-1:0] w_lb_wr [2];
  logic [PIX_W-1:0] w_lb_rd [2];

  assign pix_ready_o = win_ready_i || !r_win_valid;
  assign w_accept    = pix_valid_i && pix_ready_o;

`ifdef SOBEL_WINDOW_SOF_EN
  assign w_sof = w_accept && sof_i;
`else
  assign w_sof = 1'b0;
`endif

  // Position and state the accepted pixel is treated as having.
  assign w_col   = w_sof ? '0 : r_col;
  assign w_row   = w_sof ? '0 : r_row;
  assign w_state = w_sof ? ST_PRIME : r_state;

  // line0 holds row-2, line1 holds row-1: line1 ages into line0, pixel into line1.
  assign w_lb_wr[0] = w_lb_rd[1];
  assign w_lb_wr[1] = pix_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      sobel_line_buffer #(
        .DEPTH (IMG_W),
        .AW    (COL_W)
      ) u_line (
        .clk_i     (clk_i),
        .wr_en_i   (w_accept),
        .addr_i    (w_col),
        .wr_data_i (w_lb_wr[gi]),
        .rd_data_o (w_lb_rd[gi])
      );
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_load       = 1'b0;
    if (w_accept) begin
      w_state_next = w_state;
      w_load       = (w_state == ST_RUN) && (w_col >= COL_W'(2));
      if (w_col == COL_LAST) begin
        w_col_next = '0;
        if (w_row == ROW_LAST) begin
          w_row_next   = '0;
          w_state_next = ST_PRIME;
        end else begin
          w_row_next = w_row + 1'b1;
          if (w_state == ST_PRIME && w_row == ROW_W'(1)) begin
            w_state_next = ST_RUN;
          end
        end
      end else begin
        w_col_next = w_col + 1'b1;
      end
    end
  end

  always_comb begin
    w_win_valid_next = r_win_valid;
    if (w_load) begin
      w_win_valid_next = 1'b1;
    end else if (win_ready_i || w_sof) begin
      w_win_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_PRIME;
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_row       <= w_row_next;
      r_win_valid <= w_win_valid_next;
      // Accept is impossible while a window is stalled, so the outputs hold.
      if (w_accept) begin
        r_win <= sobel_shift(r_win, w_lb_rd[0], w_lb_rd[1], pix_i);
      end
    end
  end

  assign win_valid_o = r_win_valid;
  assign p0_o = r_win[0];
  assign p1_o = r_win[1];
  assign p2_o = r_win[2];
  assign p3_o = r_win[3];
  assign p4_o = r_win[4];
  assign p5_o = r_win[5];
  assign p6_o = r_win[6];
  assign p7_o = r_win[7];
  assign p8_o = r_win[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen at IMG_W=IMG_H=4 with hand-computed windows.
module tb_sobel_window_gen;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] pix_i;
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic [7:0] p0_o, p1_o, p2_o, p3_o, p4_o, p5_o, p6_o, p7_o, p8_o;
  logic       win_valid_o;
  logic       win_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [71:0] q_win [$];
  logic [71:0] exp_ramp [4];

  always #5 clk_i = ~clk_i;

  sobel_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .pix_i       (pix_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .p0_o        (p0_o),
    .p1_o        (p1_o),
    .p2_o        (p2_o),
    .p3_o        (p3_o),
    .p4_o        (p4_o),
    .p5_o        (p5_o),
    .p6_o        (p6_o),
    .p7_o        (p7_o),
    .p8_o        (p8_o),
    .win_valid_o (win_valid_o),
    .win_ready_i (win_ready_i)
  );

  function automatic logic [71:0] obs_win();
    return {p0_o, p1_o, p2_o, p3_o, p4_o, p5_o, p6_o, p7_o, p8_o};
  endfunction

  function automatic logic [71:0] add_base(input logic [71:0] w, input logic [7:0] b);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = w[k*8 +: 8] + b;
    return r;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Record every window handed downstream (valid && ready at the coming edge).
  always @(negedge clk_i) begin
    if (!reset_i && win_valid_o && win_ready_i) begin
      q_win.push_back(obs_win());
      $display("win %0d: p0..p8 = %h", q_win.size() - 1, obs_win());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] v);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    pix_i       = v;
    pix_valid_i = 1'b1;
    while (!acc && guard < 50) begin
      @(negedge clk_i);
      acc = pix_ready_o;
      tick();
      guard++;
    end
    pix_valid_i = 1'b0;
    if (!acc) check("pix_accept_timeout", {71'd0, acc}, 72'd1);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      send_pix(base + 8'(i));
      if (gaps && (i % 3 == 1)) begin
        tick();
        tick();
      end
    end
  endtask

  task automatic flush();
    repeat (6) tick();
  endtask

  task automatic check_frame(input string tag, input int first, input logic [7:0] base);
    for (int w = 0; w < 4; w++) begin
      if (first + w < q_win.size())
        check($sformatf("%s_win%0d", tag, w), q_win[first + w], add_base(exp_ramp[w], base));
      else
        check($sformatf("%s_win%0d_missing", tag, w), 72'(q_win.size()), 72'(first + w + 1));
    end
  endtask

  initial begin
    logic [71:0] snap;
    int          guard;

    exp_ramp[0] = {8'd0, 8'd1, 8'd2,  8'd4, 8'd5,  8'd6,  8'd8,  8'd9,  8'd10};
    exp_ramp[1] = {8'd1, 8'd2, 8'd3,  8'd5, 8'd6,  8'd7,  8'd9,  8'd10, 8'd11};
    exp_ramp[2] = {8'd4, 8'd5, 8'd6,  8'd8, 8'd9,  8'd10, 8'd12, 8'd13, 8'd14};
    exp_ramp[3] = {8'd5, 8'd6, 8'd7,  8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};

    reset_i     = 1'b1;
    pix_i       = 8'd0;
    pix_valid_i = 1'b0;
    win_ready_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("reset_win_valid", {71'd0, win_valid_o}, 72'd0);
    check("reset_pix_ready", {71'd0, pix_ready_o}, 72'd1);
    check("reset_window", obs_win(), 72'd0);
    tick();

    // Plain ramp at full rate.
    q_win.delete();
    send_frame(8'd0, 1'b0);
    flush();
    check("ramp_count", 72'(q_win.size()), 72'd4);
    check_frame("ramp", 0, 8'd0);
    if (q_win.size() == 4) check("ramp_last_p8", {64'd0, q_win[3][7:0]}, 72'd15);

    // Downstream stall for 5 cycles while a window is pending.
    q_win.delete();
    fork
      send_frame(8'd0, 1'b0);
      begin
        guard = 0;
        do begin
          @(negedge clk_i);
          guard++;
        end while (!win_valid_o && guard < 100);
        check("stall_saw_valid", {71'd0, win_valid_o}, 72'd1);
        tick();
        win_ready_i = 1'b0;
        @(negedge clk_i);
        snap = obs_win();
        check("stall_valid_start", {71'd0, win_valid_o}, 72'd1);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk_i);
          check($sformatf("stall_hold_c%0d", c), obs_win(), snap);
          check($sformatf("stall_valid_c%0d", c), {71'd0, win_valid_o}, 72'd1);
          check($sformatf("stall_ready_c%0d", c), {71'd0, pix_ready_o}, 72'd0);
        end
        tick();
        win_ready_i = 1'b1;
      end
    join
    flush();
    check("stall_count", 72'(q_win.size()), 72'd4);
    check_frame("stall", 0, 8'd0);

    // Two frames back to back; second offset by 100.
    q_win.delete();
    send_frame(8'd0, 1'b0);
    send_frame(8'd100, 1'b0);
    flush();
    check("b2b_count", 72'(q_win.size()), 72'd8);
    check_frame("b2b_f1", 0, 8'd0);
    check_frame("b2b_f2", 4, 8'd100);
    if (q_win.size() >= 5) begin
      check("b2b_f2_p0", {64'd0, q_win[4][71:64]}, 72'd100);
      check("b2b_f2_p8", {64'd0, q_win[4][7:0]}, 72'd110);
    end

    // Reset in the middle of a frame, then a clean ramp.
    q_win.delete();
    for (int i = 0; i < 7; i++) send_pix(8'(200 + i));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("midreset_pix_ready", {71'd0, pix_ready_o}, 72'd1);
    check("midreset_win_valid", {71'd0, win_valid_o}, 72'd0);
    tick();
    send_frame(8'd0, 1'b0);
    flush();
    check("midreset_count", 72'(q_win.size()), 72'd4);
    check_frame("midreset", 0, 8'd0);

    // Input gaps plus irregular downstream readiness.
    q_win.delete();
    fork
      send_frame(8'd50, 1'b1);
      begin
        for (int c = 0; c < 60; c++) begin
          tick();
          win_ready_i = ((c % 4) != 2) && ((c % 7) != 5);
        end
        tick();
        win_ready_i = 1'b1;
      end
    join
    flush();
    check("gaps_count", 72'(q_win.size()), 72'd4);
    check_frame("gaps", 0, 8'd50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
